// File: rtl/bfly_pkg.sv
// Shared types, constants and helpers for the radix-2 butterfly pipeline.
package bfly_pkg;

    localparam int DW_DEF = 9;
    localparam int TW_DEF = 9;

    // Twiddles are Q1.(TW-1): one sign/integer bit, the rest fraction.
    function automatic int frac_bits(input int tw);
        return tw - 1;
    endfunction

    typedef struct packed {
        logic signed [DW_DEF-1:0] re;
        logic signed [DW_DEF-1:0] im;
    } cplx_t;

    // Reduce v to a dw-bit signed value. Returns {overflow, value}; the
    // caller keeps the low dw bits of value. With sat_en the value is
    // clamped, otherwise it is left as-is so the low bits wrap.
    function automatic logic [32:0] sat_trunc(input logic signed [31:0] v,
                                              input int dw,
                                              input logic sat_en);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        logic signed [31:0] r;
        logic               ov;
        hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (dw - 1));
        ov = (v > hi) || (v < lo);
        r  = v;
        if (sat_en && (v > hi)) begin
            r = hi;
        end else if (sat_en && (v < lo)) begin
            r = lo;
        end
        return {ov, r};
    endfunction

endpackage

// File: rtl/bfly_pipe_if.sv
// Beat-level interface of the butterfly pipeline: input beat, output beat, overflow flag.
interface bfly_pipe_if
    import bfly_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int TW = TW_DEF
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] xr, xi, yr, yi;
    logic signed [TW-1:0] wr, wi;
    logic                 inv;
    logic                 scale;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] o0r, o0i, o1r, o1i;
    logic                 ovf;
    logic                 clr_ovf;

    modport master (
        output in_valid, xr, xi, yr, yi, wr, wi, inv, scale, out_ready, clr_ovf,
        input  in_ready, out_valid, o0r, o0i, o1r, o1i, ovf
    );

    modport slave (
        input  in_valid, xr, xi, yr, yi, wr, wi, inv, scale, out_ready, clr_ovf,
        output in_ready, out_valid, o0r, o0i, o1r, o1i, ovf
    );
endinterface

// File: rtl/bfly_cmul.sv
// Stages 1-2 of the butterfly: registered products, conjugate-aware sums and round-half-up.
module bfly_cmul
    import bfly_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int TW = TW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] xr_i,
    input  logic signed [DW-1:0] xi_i,
    input  logic signed [DW-1:0] yr_i,
    input  logic signed [DW-1:0] yi_i,
    input  logic signed [TW-1:0] wr_i,
    input  logic signed [TW-1:0] wi_i,
    input  logic                 inv_i,
    input  logic                 scale_i,
    output logic                 valid_o,
    output logic signed [DW-1:0] xr_o,
    output logic signed [DW-1:0] xi_o,
    output logic signed [DW+1:0] tr_o,
    output logic signed [DW+1:0] ti_o,
    output logic                 scale_o
);
    localparam int PW   = DW + TW;
    localparam int SW   = PW + 1;
    localparam int FRAC = frac_bits(TW);
    localparam logic signed [SW-1:0] RND = SW'(1) << (FRAC - 1);

    logic                 v1_q, inv1_q, scale1_q;
    logic signed [DW-1:0] x1r_q, x1i_q;
    logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;

    logic                 v2_q, scale2_q;
    logic signed [DW-1:0] x2r_q, x2i_q;
    logic signed [DW+1:0] tr_q, ti_q;

    logic signed [SW-1:0] pr_d, pi_d;
    logic signed [DW+1:0] tr_d, ti_d;

    // Inverse uses the conjugate twiddle, which flips the sign of every wi term.
    always_comb begin
        if (inv1_q) begin
            pr_d = SW'(p_rr_q) + SW'(p_ii_q);
            pi_d = SW'(p_ir_q) - SW'(p_ri_q);
        end else begin
            pr_d = SW'(p_rr_q) - SW'(p_ii_q);
            pi_d = SW'(p_ri_q) + SW'(p_ir_q);
        end
        tr_d = (DW+2)'((pr_d + RND) >>> FRAC);
        ti_d = (DW+2)'((pi_d + RND) >>> FRAC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else if (en) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            p_rr_q   <= PW'(yr_i) * PW'(wr_i);
            p_ii_q   <= PW'(yi_i) * PW'(wi_i);
            p_ri_q   <= PW'(yr_i) * PW'(wi_i);
            p_ir_q   <= PW'(yi_i) * PW'(wr_i);
            x1r_q    <= xr_i;
            x1i_q    <= xi_i;
            inv1_q   <= inv_i;
            scale1_q <= scale_i;
            x2r_q    <= x1r_q;
            x2i_q    <= x1i_q;
            tr_q     <= tr_d;
            ti_q     <= ti_d;
            scale2_q <= scale1_q;
        end
    end

    assign valid_o = v2_q;
    assign xr_o    = x2r_q;
    assign xi_o    = x2i_q;
    assign tr_o    = tr_q;
    assign ti_o    = ti_q;
    assign scale_o = scale2_q;
endmodule

// File: rtl/bfly_pipe.sv
// Three-stage radix-2 butterfly with global-stall handshake and sticky overflow.
// Define BFLY_SAT_EN to clamp out-of-range results; otherwise they wrap.
module bfly_pipe
    import bfly_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int TW = TW_DEF
) (
    input logic        clk,
    input logic        rst,
    bfly_pipe_if.slave bus
);
`ifdef BFLY_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    logic                 adv;
    logic                 out_valid_q, ovf_q;
    logic                 v2, scale2;
    logic signed [DW-1:0] x2r, x2i;
    logic signed [DW+1:0] t2r, t2i;

    logic signed [DW-1:0] x3 [2];
    logic signed [DW+1:0] t3 [2];
    logic signed [DW-1:0] o0_d [2];
    logic signed [DW-1:0] o1_d [2];
    logic signed [DW-1:0] o0_q [2];
    logic signed [DW-1:0] o1_q [2];
    logic [1:0]           ov_d;

    // Whole pipeline moves together; an unconsumed output freezes every stage.
    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv;

    bfly_cmul #(.DW(DW), .TW(TW)) u_cmul (
        .clk      (clk),
        .rst      (rst),
        .en       (adv),
        .in_valid (bus.in_valid),
        .xr_i     (bus.xr),
        .xi_i     (bus.xi),
        .yr_i     (bus.yr),
        .yi_i     (bus.yi),
        .wr_i     (bus.wr),
        .wi_i     (bus.wi),
        .inv_i    (bus.inv),
        .scale_i  (bus.scale),
        .valid_o  (v2),
        .xr_o     (x2r),
        .xi_o     (x2i),
        .tr_o     (t2r),
        .ti_o     (t2i),
        .scale_o  (scale2)
    );

    assign x3[0] = x2r;
    assign x3[1] = x2i;
    assign t3[0] = t2r;
    assign t3[1] = t2i;

    // Index 0 is the real component, index 1 the imaginary one.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_comp
            logic signed [DW+2:0] s0, s1, s0_sc, s1_sc;
            always_comb begin
                s0    = (DW+3)'(x3[gi]) + (DW+3)'(t3[gi]);
                s1    = (DW+3)'(x3[gi]) - (DW+3)'(t3[gi]);
                s0_sc = scale2 ? (s0 >>> 1) : s0;
                s1_sc = scale2 ? (s1 >>> 1) : s1;
            end
            assign o0_d[gi] = DW'(sat_trunc(32'(s0_sc), DW, SAT_EN));
            assign o1_d[gi] = DW'(sat_trunc(32'(s1_sc), DW, SAT_EN));
            assign ov_d[gi] = 1'(sat_trunc(32'(s0_sc), DW, SAT_EN) >> 32)
                            | 1'(sat_trunc(32'(s1_sc), DW, SAT_EN) >> 32);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            o0_q[0]     <= '0;
            o0_q[1]     <= '0;
            o1_q[0]     <= '0;
            o1_q[1]     <= '0;
        end else begin
            if (adv) begin
                out_valid_q <= v2;
                if (v2) begin
                    o0_q[0] <= o0_d[0];
                    o0_q[1] <= o0_d[1];
                    o1_q[0] <= o1_d[0];
                    o1_q[1] <= o1_d[1];
                end
            end
            // A new overflow outranks a simultaneous clear.
            if (adv && v2 && (|ov_d)) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.o0r       = o0_q[0];
    assign bus.o0i       = o0_q[1];
    assign bus.o1r       = o1_q[0];
    assign bus.o1i       = o1_q[1];
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_bfly_pipe.sv
// Directed, table-driven bench for bfly_pipe: vectors, sticky ovf, backpressure, mid-flight reset.
module tb_bfly_pipe;
    import bfly_pkg::*;

    localparam int DW = DW_DEF;
    localparam int TW = TW_DEF;
`ifdef BFLY_SAT_EN
    localparam int OV_HI = 255;
    localparam int OV_LO = -256;
`else
    localparam int OV_HI = -3;
    localparam int OV_LO = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bfly_pipe_if #(.DW(DW), .TW(TW)) bus ();
    bfly_pipe #(.DW(DW), .TW(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        cplx_t x, y, w;
        logic  inv, sc;
        cplx_t e0, e1;
        logic  eovf;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic cplx_t c(input int re, input int im);
        cplx_t r;
        r.re = DW'(re);
        r.im = DW'(im);
        return r;
    endfunction

    function automatic vec_t mk(input cplx_t x, input cplx_t y, input cplx_t w,
                                input logic inv, input logic sc,
                                input cplx_t e0, input cplx_t e1, input logic eovf);
        vec_t v;
        v.x = x; v.y = y; v.w = w; v.inv = inv; v.sc = sc;
        v.e0 = e0; v.e1 = e1; v.eovf = eovf;
        return v;
    endfunction

    task automatic drive_beat(input cplx_t x, input cplx_t y, input cplx_t w,
                              input logic inv, input logic sc);
        bus.xr = x.re; bus.xi = x.im;
        bus.yr = y.re; bus.yi = y.im;
        bus.wr = w.re; bus.wi = w.im;
        bus.inv = inv; bus.scale = sc;
    endtask

    // clr_mode: 0 = no clear, 1 = clear pulse on the accept edge, 2 = keep clr_ovf high.
    task automatic run_vec(input int idx, input vec_t v, input int clr_mode);
        int lat;
        @(negedge clk);
        bus.clr_ovf   = (clr_mode != 0);
        drive_beat(v.x, v.y, v.w, v.inv, v.sc);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk($sformatf("v%0d in_ready", idx), int'(bus.in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (clr_mode != 2) bus.clr_ovf = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("v%0d latency", idx), lat, 3);
        chk($sformatf("v%0d o0r", idx), int'(bus.o0r), int'(v.e0.re));
        chk($sformatf("v%0d o0i", idx), int'(bus.o0i), int'(v.e0.im));
        chk($sformatf("v%0d o1r", idx), int'(bus.o1r), int'(v.e1.re));
        chk($sformatf("v%0d o1i", idx), int'(bus.o1i), int'(v.e1.im));
        chk($sformatf("v%0d ovf", idx), int'(bus.ovf), int'(v.eovf));
        $display("vec %0d: lat=%0d o0=(%0d,%0d) o1=(%0d,%0d) ovf=%0d",
                 idx, lat, bus.o0r, bus.o0i, bus.o1r, bus.o1i, bus.ovf);
    endtask

    initial begin
        int   sent, recv, cyc, k, extra;
        logic stall_prev, acc;
        int   prev [4];
        vec_t v;

        vecs[0] = mk(c(10, 0),  c(100, 0),  c(128, 0),   0, 0, c(60, 0),    c(-40, 0), 0);
        vecs[1] = mk(c(0, 0),   c(3, 0),    c(128, 0),   0, 0, c(2, 0),     c(-2, 0),  0);
        vecs[2] = mk(c(0, 0),   c(100, 0),  c(0, 128),   0, 0, c(0, 50),    c(0, -50), 0);
        vecs[3] = mk(c(0, 0),   c(100, 0),  c(0, 128),   1, 0, c(0, -50),   c(0, 50),  0);
        vecs[4] = mk(c(255, 0), c(255, 0),  c(255, 0),   0, 0, c(OV_HI, 0), c(1, 0),   1);
        vecs[5] = mk(c(255, 0), c(255, 0),  c(255, 0),   0, 1, c(254, 0),   c(0, 0),   0);
        vecs[6] = mk(c(-20, 30), c(50, -60), c(64, -100), 0, 0, c(-31, -5), c(-9, 65), 0);
        vecs[7] = mk(c(-20, 30), c(50, -60), c(64, -100), 1, 1, c(8, 17),   c(-28, 12), 0);
        vecs[8] = mk(c(-256, 0), c(-256, 0), c(255, 0),  0, 0, c(OV_LO, 0), c(-1, 0),  1);
        vecs[9] = mk(c(5, -5),  c(0, 100),  c(0, -256),  0, 0, c(105, -5),  c(-95, -5), 0);

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.clr_ovf = 1'b0;
        drive_beat(c(0, 0), c(0, 0), c(0, 0), 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset out_valid", int'(bus.out_valid), 0);
        chk("reset in_ready", int'(bus.in_ready), 1);
        chk("reset ovf", int'(bus.ovf), 0);
        chk("reset o0r", int'(bus.o0r), 0);
        chk("reset o0i", int'(bus.o0i), 0);
        chk("reset o1r", int'(bus.o1r), 0);
        chk("reset o1i", int'(bus.o1i), 0);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i], 1);

        // Sticky ovf: overflow beat, then an in-range beat without clearing.
        run_vec(10, vecs[4], 1);
        v = vecs[5];
        v.eovf = 1'b1;
        run_vec(11, v, 0);
        @(negedge clk); bus.clr_ovf = 1'b1;
        @(negedge clk); bus.clr_ovf = 1'b0;
        chk("ovf after clear", int'(bus.ovf), 0);
        $display("ovf clear: ovf=%0d", bus.ovf);

        // Set beats clear when both happen on the same edge.
        run_vec(12, vecs[4], 2);
        @(negedge clk);
        chk("ovf clr held after set", int'(bus.ovf), 0);
        bus.clr_ovf = 1'b0;
        $display("set-vs-clear: ovf=%0d", bus.ovf);

        // Backpressure stream.
        sent = 0; recv = 0; cyc = 0; stall_prev = 1'b0;
        prev = '{0, 0, 0, 0};
        while (recv < 8 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_valid  = (sent < 8);
            k = sent + 1;
            drive_beat(c(k, 2 * k), c(20 * k, -10 * k), c(128, 0), 1'b0, 1'b0);
            #1;
            chk("bp in_ready", int'(bus.in_ready), int'(!bus.out_valid || bus.out_ready));
            if (stall_prev) begin
                chk("bp hold valid", int'(bus.out_valid), 1);
                chk("bp hold o0r", int'(bus.o0r), prev[0]);
                chk("bp hold o0i", int'(bus.o0i), prev[1]);
                chk("bp hold o1r", int'(bus.o1r), prev[2]);
                chk("bp hold o1i", int'(bus.o1i), prev[3]);
            end
            if (bus.out_valid && bus.out_ready) begin
                k = recv + 1;
                chk($sformatf("bp%0d o0r", k), int'(bus.o0r), 11 * k);
                chk($sformatf("bp%0d o0i", k), int'(bus.o0i), -3 * k);
                chk($sformatf("bp%0d o1r", k), int'(bus.o1r), -9 * k);
                chk($sformatf("bp%0d o1i", k), int'(bus.o1i), 7 * k);
                $display("bp beat %0d: o0=(%0d,%0d) o1=(%0d,%0d) cyc=%0d",
                         k, bus.o0r, bus.o0i, bus.o1r, bus.o1i, cyc);
                recv++;
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            prev[0] = int'(bus.o0r); prev[1] = int'(bus.o0i);
            prev[2] = int'(bus.o1r); prev[3] = int'(bus.o1i);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (acc) sent++;
        end
        chk("bp beats received", recv, 8);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) extra++;
        end
        chk("bp no duplicates", extra, 0);

        // Reset with two overflow beats in flight.
        @(negedge clk); bus.clr_ovf = 1'b1;
        @(negedge clk); bus.clr_ovf = 1'b0;
        drive_beat(vecs[4].x, vecs[4].y, vecs[4].w, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive_beat(vecs[8].x, vecs[8].y, vecs[8].w, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("rst out_valid", int'(bus.out_valid), 0);
        chk("rst ovf", int'(bus.ovf), 0);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) extra++;
        end
        chk("rst discarded beats", extra, 0);
        chk("rst ovf later", int'(bus.ovf), 0);
        $display("mid-flight reset: spurious outputs=%0d ovf=%0d", extra, bus.ovf);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
